icache_fill: RTL and testbench

Instruction-cache fill engine: on a `start` pulse it fetches `count` consecutive 32-bit words from instruction memory over a request/acknowledge handshake and writes each word into `icache` through the cache's single-cycle write port. It is the write-side driver for `icache`; its `write`/`write_addr`/`write_data` outputs connect directly to the cache's write inputs. One fill runs at a time; the core polls `busy` or waits for `done`.

---
 rtl/icache_fill_pkg.sv | 17 +
 rtl/icache_fill.sv | 102 ++++++++++
 tb/tb_icache_fill.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_pkg.sv
// Shared types for the instruction-cache fill engine and the cache write port.
package icache_fill_pkg;

    localparam int unsigned ICACHE_DEPTH = 32;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_DEPTH);

    typedef logic [ICACHE_IDX_W-1:0] address;
    typedef logic [31:0]             word;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWrite,
        StDone
    } fill_state_t;

endpackage

// File: rtl/icache_fill.sv
// Fill engine: fetches count consecutive words over a req/ack handshake and writes
// each one into the instruction cache through its single-cycle write port.
module icache_fill
    import icache_fill_pkg::*;
#(
    parameter int unsigned DEPTH = ICACHE_DEPTH,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_start,
    input  logic [31:0]      i_base_addr,
    input  logic [IDX_W:0]   i_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_mem_req,
    output logic [31:0]      o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [31:0]      i_mem_rdata,
    output logic             o_write,
    output logic [IDX_W-1:0] o_write_addr,
    output word              o_write_data
);

    localparam logic [IDX_W:0] CountMax = (IDX_W+1)'(DEPTH);

    fill_state_t      r_state, w_state_nxt;
    logic [31:0]      r_base, w_base_nxt;
    logic [IDX_W:0]   r_count, w_count_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    word              r_data, w_data_nxt;

    logic [IDX_W:0]   w_count_clamp;
    logic [31:0]      w_offset;

    assign w_count_clamp = (i_count > CountMax) ? CountMax : i_count;
    assign w_offset      = {{(30-IDX_W){1'b0}}, r_idx, 2'b00};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= StIdle;
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_base_nxt  = i_base_addr & 32'hFFFF_FFFC;
                    w_count_nxt = w_count_clamp;
                    w_idx_nxt   = '0;
                    w_state_nxt = (w_count_clamp == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (i_mem_ack) begin
                    w_data_nxt  = i_mem_rdata;
                    w_state_nxt = StWrite;
                end
            end
            StWrite: begin
                if (({1'b0, r_idx} + (IDX_W+1)'(1)) == r_count) begin
                    w_state_nxt = StDone;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = StReq;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Address/data outputs are gated so they read zero outside their strobe cycles.
    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StDone);
    assign o_mem_req    = (r_state == StReq);
    assign o_mem_addr   = o_mem_req ? (r_base + w_offset) : '0;
    assign o_write      = (r_state == StWrite);
    assign o_write_addr = o_write ? r_idx : '0;
    assign o_write_data = o_write ? r_data : '0;

endmodule

// File: tb/tb_icache_fill.sv
// Randomised bench for icache_fill: a memory responder with random wait states and
// a word-level reference model of which writes land where and when.
module tb_icache_fill;

    localparam int unsigned Depth = 32;
    localparam int unsigned IdxW  = 5;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            i_start = 1'b0;
    logic [31:0]     i_base_addr = '0;
    logic [IdxW:0]   i_count = '0;
    logic            o_busy, o_done, o_mem_req, o_write;
    logic [31:0]     o_mem_addr, o_write_data;
    logic            i_mem_ack = 1'b0;
    logic [31:0]     i_mem_rdata = '0;
    logic [IdxW-1:0] o_write_addr;

    always #5 clk = ~clk;

    icache_fill #(.DEPTH(Depth), .IDX_W(IdxW)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_count      (i_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .o_write      (o_write),
        .o_write_addr (o_write_addr),
        .o_write_data (o_write_data)
    );

    typedef struct {
        int              rel;
        logic [IdxW-1:0] idx;
        logic [31:0]     data;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    wr_t         wr_q[$];
    logic [31:0] req_q[$];
    int          done_q[$];
    int          wait_q[$];
    int unsigned wmin = 0;
    int unsigned wmax = 0;
    logic [31:0] salt = '0;
    bit          noise = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: a fresh random wait per request, then one ack cycle with addr ^ salt.
    initial begin : responder
        int  left;
        bit  active;
        left   = 0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst || !o_mem_req) begin
                active      = 1'b0;
                i_mem_ack   = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                i_mem_rdata = $urandom();
            end else begin
                if (!active) begin
                    active = 1'b1;
                    left   = int'($urandom_range(wmax, wmin));
                    wait_q.push_back(left);
                end
                if (left == 0) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = o_mem_addr ^ salt;
                    active      = 1'b0;
                end else begin
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = $urandom();
                    left--;
                end
            end
        end
    end

    initial begin : monitor
        int          rel;
        logic        prev_req;
        logic [31:0] prev_addr;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (nrst) begin
                rel = cyc - start_cyc + 1;
                if (o_write) wr_q.push_back('{rel, o_write_addr, o_write_data});
                if (o_mem_req && prev_req) check("addr_hold", o_mem_addr, prev_addr);
                if (o_mem_req && !prev_req) req_q.push_back(o_mem_addr);
                if (o_done) begin
                    done_q.push_back(rel);
                    check("busy_at_done", o_busy, 1);
                end
                prev_req  = o_mem_req;
                prev_addr = o_mem_addr;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_req"}, o_mem_req, 0);
        check({tag, "_maddr"}, o_mem_addr, 0);
        check({tag, "_write"}, o_write, 0);
        check({tag, "_waddr"}, o_write_addr, 0);
        check({tag, "_wdata"}, o_write_data, 0);
    endtask

    task automatic run_fill(input logic [31:0] base, input int unsigned cnt,
                            input int unsigned wmn, input int unsigned wmx,
                            input logic [31:0] s, input bit spam, input bit rst_mid);
        int          n, acc, w, n_chk;
        bit          stop, rst_pending;
        logic [31:0] exp_addr;
        wmin = wmn;
        wmax = wmx;
        salt = s;
        @(negedge clk); #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_count     = (IdxW+1)'(cnt);
        @(posedge clk); #1;
        start_cyc = cyc;
        wr_q.delete(); req_q.delete(); done_q.delete(); wait_q.delete();
        if (!spam) i_start = 1'b0;
        stop        = 1'b0;
        rst_pending = 1'b0;
        for (int t = 0; t < 3000 && !stop; t++) begin
            @(negedge clk); #1;
            if (spam) begin
                i_start     = 1'b1;
                i_base_addr = $urandom();
                i_count     = (IdxW+1)'($urandom_range(40, 0));
            end
            if (done_q.size() > 0) stop = 1'b1;
            if (rst_mid) begin
                if (rst_pending) begin
                    nrst = 1'b0;
                    #1;
                    check_idle_outputs("rst_mid");
                    stop = 1'b1;
                end else if (wr_q.size() == 2) begin
                    rst_pending = 1'b1;
                end
            end
        end
        check("finished_in_budget", stop, 1);

        n   = (cnt > Depth) ? Depth : int'(cnt);
        acc = 1;
        if (rst_mid) begin
            repeat (2) @(negedge clk);
            #1 nrst = 1'b1;
            repeat (4) @(negedge clk);
            #1;
            check("rst_no_more_writes", wr_q.size(), 2);
            check("rst_idle_busy", o_busy, 0);
            n_chk = 2;
        end else begin
            if (spam) begin
                @(negedge clk); #1;
                i_start = 1'b0;
                check("start_at_done_ignored", o_busy, 0);
                @(negedge clk); #1;
                check("still_idle", o_busy, 0);
            end
            repeat (3) @(negedge clk);
            #1;
            check("n_writes", wr_q.size(), n);
            check("n_reqs", req_q.size(), n);
            check("n_done", done_q.size(), 1);
            n_chk = n;
        end

        for (int k = 0; k < n_chk; k++) begin
            w        = (k < wait_q.size()) ? wait_q[k] : 0;
            exp_addr = (base & 32'hFFFF_FFFC) + 32'(4 * k);
            if (k < req_q.size()) check("mem_addr", req_q[k], exp_addr);
            if (k < wr_q.size()) begin
                check("wr_idx", wr_q[k].idx, k);
                check("wr_data", wr_q[k].data, exp_addr ^ s);
                check("wr_cycle", wr_q[k].rel, acc + w + 1);
            end
            acc += 2 + w;
        end
        if (!rst_mid && done_q.size() > 0) check("done_cycle", done_q[0], acc);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: zero-wait, fixed waits, empty fill, clamp, wrap.
        run_fill(32'h0000_1000, 4, 0, 0, 32'hA000_0000, 1'b0, 1'b0);
        run_fill(32'h0000_2000, 2, 3, 3, 32'hA000_0000, 1'b0, 1'b0);
        run_fill(32'h0000_3000, 0, 0, 0, 32'hA000_0000, 1'b0, 1'b0);
        noise = 1'b1;
        run_fill($urandom(), 40, 0, 2, $urandom(), 1'b0, 1'b0);
        run_fill(32'hFFFF_FFF8, 4, 0, 1, $urandom(), 1'b0, 1'b0);
        run_fill(32'hFFFF_FFFB, 3, 0, 0, $urandom(), 1'b0, 1'b0);

        // start hammered throughout the fill, including the done cycle.
        run_fill(32'h0000_4000, 5, 0, 2, $urandom(), 1'b1, 1'b0);

        // Reset one cycle after the second write, then a clean refill.
        noise = 1'b0;
        run_fill(32'h0000_5000, 8, 0, 0, 32'h5A5A_0000, 1'b0, 1'b1);
        run_fill(32'h0000_5000, 8, 0, 0, 32'h5A5A_0000, 1'b0, 1'b0);

        noise = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_fill($urandom(), $urandom_range(40, 0), 0, 3, $urandom(), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
